// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory: access size enum,
// lane count, byte-enable mask and load extension.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } mem_size_e;

   function automatic logic [3:0] byte_lanes(input mem_size_e sz);
      return 4'd1 << sz;
   endfunction

   // Mask is built for the widest (8-lane) data path; narrower callers slice it.
   function automatic logic [7:0] be_mask(input mem_size_e sz, input logic [2:0] off);
      logic [7:0] m;
      m = 8'((16'd1 << byte_lanes(sz)) - 16'd1);
      return m << off;
   endfunction

   function automatic logic [63:0] load_ext(input logic [63:0] raw, input mem_size_e sz,
                                            input logic uns);
      case (sz)
         SZ_B:    return uns ? {56'b0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
         SZ_H:    return uns ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
         SZ_W:    return uns ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
         default: return raw;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lsu_ram_bank.sv
// Plain byte-enabled synchronous RAM with registered read; kept separate so it can
// be swapped for an SRAM macro. Adds one even-parity bit per byte under DMEM_PARITY_EN.
module dmem_bank #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 2048,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic                    re,
   input  logic [IDX_W-1:0]        idx,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [DATA_WIDTH-1:0]   wdata,
`ifdef DMEM_PARITY_EN
   output logic [DATA_WIDTH/8-1:0] rpar,
`endif
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
   logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem[idx];
   end

   always_ff @(posedge clk) rdata_q <= rdata_d;

   assign rdata = rdata_q;

`ifdef DMEM_PARITY_EN
   logic [NB-1:0] par_mem [DEPTH_WORDS];
   logic [NB-1:0] wpar;
   logic [NB-1:0] rpar_d, rpar_q;

   always_comb begin
      wpar = '0;
      for (int i = 0; i < NB; i++) wpar[i] = ^wdata[i*8 +: 8];
   end

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) par_mem[idx][i] <= wpar[i];
         end
      end
   end

   always_comb begin
      rpar_d = rpar_q;
      if (re) rpar_d = par_mem[idx];
   end

   always_ff @(posedge clk) rpar_q <= rpar_d;

   assign rpar = rpar_q;
`endif

endmodule

// File: rtl/dmem_lsu_ram.sv
// MEM-stage data memory: valid/ready handshake, one-cycle registered read, sub-word
// stores and extended loads, error reporting. Optional byte parity via DMEM_PARITY_EN.
//
// state   | meaning
// IDLE    | no response pending, request always accepted
// RESP    | response presented and held; new request accepted only with resp_ready
module dmem_lsu_ram
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 2048,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int LSB   = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic {ST_IDLE, ST_RESP} state_e;

   state_e           state_d, state_q;
   logic             err_d, err_q;
   logic             load_d, load_q;
   mem_size_e        size_d, size_q;
   logic [LSB-1:0]   off_d, off_q;
   logic             uns_d, uns_q;

   mem_size_e        sz;
   logic [LSB-1:0]   req_off;
   logic [3:0]       lanes;
   logic             misalign, size_bad, range_bad, req_err;
   logic             accept, wr_en, rd_en;
   logic [7:0]       be_full;
   logic [NB-1:0]    be;
   logic [DATA_WIDTH-1:0] wdata_rep;
   logic [DATA_WIDTH-1:0] bank_rdata, raw;
   logic [63:0]      ext_full;
   logic             par_err;

   assign sz        = mem_size_e'(req_size);
   assign req_off   = req_addr[LSB-1:0];
   assign lanes     = byte_lanes(sz);
   assign misalign  = |(req_addr[2:0] & 3'(lanes - 4'd1));
   assign size_bad  = (sz == SZ_D) && (DATA_WIDTH == 32);
   assign range_bad = (req_addr >> (LSB + IDX_W)) != '0;
   assign req_err   = misalign | size_bad | range_bad;

   assign req_ready = (state_q == ST_IDLE) || resp_ready;
   assign accept    = req_valid && req_ready;
   assign wr_en     = accept && req_we && !req_err;
   assign rd_en     = accept && !req_we && !req_err;

   assign be_full = be_mask(sz, 3'(req_off));
   assign be      = be_full[NB-1:0];

   // Aligned accesses put the offset on a multiple of the lane count, so lane i
   // always takes source byte (i mod lanes).
   always_comb begin
      wdata_rep = '0;
      for (int i = 0; i < NB; i++) begin
         wdata_rep[i*8 +: 8] = req_wdata[(i % int'(lanes))*8 +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      load_d  = load_q;
      size_d  = size_q;
      off_d   = off_q;
      uns_d   = uns_q;
      if (accept) begin
         state_d = ST_RESP;
         err_d   = req_err;
         load_d  = !req_we && !req_err;
         size_d  = sz;
         off_d   = req_off;
         uns_d   = req_unsigned;
      end else if (state_q == ST_RESP && resp_ready) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         err_q   <= 1'b0;
         load_q  <= 1'b0;
         size_q  <= SZ_B;
         off_q   <= '0;
         uns_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         load_q  <= load_d;
         size_q  <= size_d;
         off_q   <= off_d;
         uns_q   <= uns_d;
      end
   end

`ifdef DMEM_PARITY_EN
   logic [NB-1:0] be_d, be_q;
   logic [NB-1:0] bank_rpar, calc_par;

   assign be_d = accept ? be : be_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) be_q <= '0;
      else        be_q <= be_d;
   end

   always_comb begin
      calc_par = '0;
      for (int i = 0; i < NB; i++) calc_par[i] = ^bank_rdata[i*8 +: 8];
   end

   assign par_err = load_q && |(be_q & (calc_par ^ bank_rpar));
`else
   assign par_err = 1'b0;
`endif

   dmem_bank #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_bank (
      .clk   (clk),
      .we    (wr_en),
      .re    (rd_en),
      .idx   (req_addr[LSB +: IDX_W]),
      .be    (be),
      .wdata (wdata_rep),
`ifdef DMEM_PARITY_EN
      .rpar  (bank_rpar),
`endif
      .rdata (bank_rdata)
   );

   // Bank output only changes on an accepted load, so the extended view of it is
   // stable for as long as the response is stalled.
   assign raw      = bank_rdata >> {off_q, 3'b000};
   assign ext_full = load_ext(64'(raw), size_q, uns_q);

   logic unused_ext;
   assign unused_ext = ^ext_full;

   assign resp_valid = (state_q == ST_RESP);
   assign resp_err   = resp_valid && (err_q || par_err);
   assign resp_rdata = (resp_valid && load_q && !par_err) ? ext_full[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_dmem_lsu_ram.sv
// Directed self-checking bench for dmem_lsu_ram (32-bit data, 2048 words).
module tb_dmem_lsu_ram;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_lsu_ram #(
      .DATA_WIDTH  (32),
      .DEPTH_WORDS (2048),
      .ADDR_WIDTH  (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err)
   );

   // Presents one request with resp_ready=1; returns 1 time unit after the accept edge.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
      req_valid    = 1'b1;
      req_we       = we;
      req_addr     = addr;
      req_size     = size;
      req_unsigned = uns;
      req_wdata    = wdata;
      resp_ready   = 1'b1;
      @(posedge clk); #1;
      req_valid    = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", resp_valid); end
      checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", resp_rdata); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", resp_err); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_store_load();
      do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
         errors++; $display("FAIL sw_ack: got v=%b e=%b d=%h exp v=1 e=0 d=0", resp_valid, resp_err, resp_rdata);
      end
      do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL lw_0x10: got v=%b e=%b d=%h exp v=1 e=0 d=deadbeef", resp_valid, resp_err, resp_rdata);
      end
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_after: got %b exp 0", resp_valid); end
   endtask

   task automatic test_subword();
      do_req(1'b1, 32'h11, 2'b00, 1'b0, 32'h00000080);
      do_req(1'b0, 32'h11, 2'b00, 1'b0, 32'h0);
      checks++; if (resp_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_0x11: got %h exp ffffff80", resp_rdata); end
      do_req(1'b0, 32'h11, 2'b00, 1'b1, 32'h0);
      checks++; if (resp_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_0x11: got %h exp 00000080", resp_rdata); end
      do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
      checks++; if (resp_rdata !== 32'hDEAD80EF) begin errors++; $display("FAIL lw_after_sb: got %h exp dead80ef", resp_rdata); end
      do_req(1'b0, 32'h12, 2'b01, 1'b0, 32'h0);
      checks++; if (resp_rdata !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh_0x12: got %h exp ffffdead", resp_rdata); end
      do_req(1'b0, 32'h12, 2'b01, 1'b1, 32'h0);
      checks++; if (resp_rdata !== 32'h0000DEAD) begin errors++; $display("FAIL lhu_0x12: got %h exp 0000dead", resp_rdata); end
      do_req(1'b1, 32'h50, 2'b10, 1'b0, 32'hAAAAAAAA);
      do_req(1'b1, 32'h52, 2'b01, 1'b0, 32'hFFFF1234);
      do_req(1'b0, 32'h50, 2'b10, 1'b0, 32'h0);
      checks++; if (resp_rdata !== 32'h1234AAAA) begin errors++; $display("FAIL lw_after_sh: got %h exp 1234aaaa", resp_rdata); end
      do_req(1'b0, 32'h50, 2'b10, 1'b1, 32'h0);
      checks++; if (resp_rdata !== 32'h1234AAAA) begin errors++; $display("FAIL lwu_full: got %h exp 1234aaaa", resp_rdata); end
   endtask

   task automatic test_misaligned();
      do_req(1'b0, 32'h13, 2'b01, 1'b0, 32'h0);
      checks++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
         errors++; $display("FAIL lh_0x13: got e=%b d=%h exp e=1 d=0", resp_err, resp_rdata);
      end
      do_req(1'b1, 32'h12, 2'b10, 1'b0, 32'hFFFFFFFF);
      checks++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
         errors++; $display("FAIL sw_0x12: got e=%b d=%h exp e=1 d=0", resp_err, resp_rdata);
      end
      do_req(1'b0, 32'h10, 2'b11, 1'b0, 32'h0);
      checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL size_d_on_32: got %b exp 1", resp_err); end
      do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
      checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'hDEAD80EF) begin
         errors++; $display("FAIL lw_unchanged: got e=%b d=%h exp e=0 d=dead80ef", resp_err, resp_rdata);
      end
   endtask

   task automatic test_range();
      do_req(1'b1, 32'h0, 2'b10, 1'b0, 32'h11111111);
      do_req(1'b1, 32'h2000, 2'b10, 1'b0, 32'h22222222);
      checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL sw_0x2000: got %b exp 1", resp_err); end
      do_req(1'b0, 32'h2000, 2'b10, 1'b0, 32'h0);
      checks++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
         errors++; $display("FAIL lw_0x2000: got e=%b d=%h exp e=1 d=0", resp_err, resp_rdata);
      end
      do_req(1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
      checks++; if (resp_rdata !== 32'h11111111) begin errors++; $display("FAIL no_alias_0: got %h exp 11111111", resp_rdata); end
      do_req(1'b1, 32'h1FFC, 2'b10, 1'b0, 32'h33333333);
      do_req(1'b0, 32'h1FFC, 2'b10, 1'b0, 32'h0);
      checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'h33333333) begin
         errors++; $display("FAIL lw_last: got e=%b d=%h exp e=0 d=33333333", resp_err, resp_rdata);
      end
   endtask

   task automatic test_back_to_back();
      do_req(1'b1, 32'h20, 2'b10, 1'b0, 32'hA0A0A0A0);
      do_req(1'b1, 32'h24, 2'b10, 1'b0, 32'hB1B1B1B1);
      do_req(1'b1, 32'h28, 2'b10, 1'b0, 32'hC2C2C2C2);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h20; resp_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (resp_rdata !== 32'hA0A0A0A0) begin errors++; $display("FAIL b2b_a: got %h exp a0a0a0a0", resp_rdata); end
      req_addr = 32'h24; resp_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (resp_rdata !== 32'hB1B1B1B1) begin errors++; $display("FAIL b2b_b: got %h exp b1b1b1b1", resp_rdata); end
      req_addr = 32'h28; resp_ready = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b exp 0", req_ready); end
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hB1B1B1B1 || resp_err !== 1'b0) begin
            errors++; $display("FAIL stall_hold%0d: got v=%b d=%h e=%b exp v=1 d=b1b1b1b1 e=0", k, resp_valid, resp_rdata, resp_err);
         end
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (resp_rdata !== 32'hC2C2C2C2) begin errors++; $display("FAIL b2b_c: got %h exp c2c2c2c2", resp_rdata); end
      req_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup: got %b exp 0", resp_valid); end
   endtask

   task automatic test_reset_mid_resp();
      do_req(1'b1, 32'h30, 2'b10, 1'b0, 32'hCAFEF00D);
      rst_n = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin
         errors++; $display("FAIL rst_store_resp: got v=%b e=%b exp v=0 e=0", resp_valid, resp_err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
      resp_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
         errors++; $display("FAIL rst_load_resp: got v=%b d=%h exp v=0 d=0", resp_valid, resp_rdata);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; resp_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_retry: got %b exp 0", resp_valid); end
      do_req(1'b0, 32'h30, 2'b10, 1'b0, 32'h0);
      checks++; if (resp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL store_committed: got %h exp cafef00d", resp_rdata); end
      do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
      checks++; if (resp_rdata !== 32'hDEAD80EF) begin errors++; $display("FAIL mem_retained: got %h exp dead80ef", resp_rdata); end
   endtask

`ifdef DMEM_PARITY_EN
   task automatic test_parity();
      do_req(1'b1, 32'h40, 2'b10, 1'b0, 32'h01020304);
      do_req(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
      checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'h01020304) begin
         errors++; $display("FAIL par_clean: got e=%b d=%h exp e=0 d=01020304", resp_err, resp_rdata);
      end
      dut.u_bank.mem[16] = dut.u_bank.mem[16] ^ 32'h00000001;
      do_req(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
      checks++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
         errors++; $display("FAIL par_flip_lw: got e=%b d=%h exp e=1 d=0", resp_err, resp_rdata);
      end
      do_req(1'b0, 32'h41, 2'b00, 1'b1, 32'h0);
      checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'h00000003) begin
         errors++; $display("FAIL par_other_byte: got e=%b d=%h exp e=0 d=00000003", resp_err, resp_rdata);
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'b00;
      req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b1;
      test_reset();
      test_store_load();
      test_subword();
      test_misaligned();
      test_range();
      test_back_to_back();
      test_reset_mid_resp();
`ifdef DMEM_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
